// File: rtl/pattern_sequencer_pkg.sv
// Shared types and width helpers for the pattern sequencer.
package pattern_sequencer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_t;

    // Bits needed to index n items (ceil(log2(n))), never less than 1 so
    // that single-channel or single-step builds still get a real bus.
    function automatic int width_of(input int n);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/pattern_channel.sv
// One sequencer channel: shadow/active pattern registers, step index and
// the IDLE/RUN controller. Steps only on the shared prescaler tick.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | output parked at the polarity level, waiting for a pending load
//   RUN   | shifting out active_pattern[idx], one bit per tick
module pattern_channel
    import pattern_sequencer_pkg::*;
#(
    parameter int   PAT_LEN = 32,
    parameter int   LEN_W   = 5,
    parameter logic POL     = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               wr,
    input  logic [PAT_LEN-1:0] wr_pattern,
    input  logic [LEN_W-1:0]   wr_len,
    input  logic               wr_oneshot,
    input  logic               stop,
    output logic               pending,
    output logic               out,
    output logic               busy,
    output logic               done
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_LEN - 1);

    chan_state_t        state;
    logic [LEN_W-1:0]   idx;
    logic [PAT_LEN-1:0] act_pattern;
    logic [LEN_W-1:0]   act_len;
    logic               act_oneshot;
    logic [PAT_LEN-1:0] shd_pattern;
    logic [LEN_W-1:0]   shd_len;
    logic               shd_oneshot;
    logic [LEN_W-1:0]   len_clamped;

    // A length field can only exceed the pattern when PAT_LEN is not a power of two.
    if ((1 << LEN_W) == PAT_LEN) begin : g_no_clamp
        assign len_clamped = wr_len;
    end else begin : g_clamp
        assign len_clamped = (wr_len > LEN_MAX) ? LEN_MAX : wr_len;
    end

    // Channel controller; the shadow write is last so a load in the same
    // cycle as stop survives the stop and restarts the channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            idx         <= '0;
            pending     <= 1'b0;
            done        <= 1'b0;
            act_pattern <= '0;
            act_len     <= '0;
            act_oneshot <= 1'b0;
            shd_pattern <= '0;
            shd_len     <= '0;
            shd_oneshot <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state   <= IDLE;
                idx     <= '0;
                pending <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (pending) begin
                            act_pattern <= shd_pattern;
                            act_len     <= shd_len;
                            act_oneshot <= shd_oneshot;
                            pending     <= 1'b0;
                            idx         <= '0;
                            state       <= RUN;
                        end
                    end
                    RUN: begin
                        if (tick) begin
                            if (idx != act_len) begin
                                idx <= idx + 1'b1;
                            end else if (pending) begin
                                act_pattern <= shd_pattern;
                                act_len     <= shd_len;
                                act_oneshot <= shd_oneshot;
                                pending     <= 1'b0;
                                idx         <= '0;
                            end else if (!act_oneshot) begin
                                idx <= '0;
                            end else begin
                                idx   <= '0;
                                state <= IDLE;
                                done  <= 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
            if (wr) begin
                shd_pattern <= wr_pattern;
                shd_len     <= len_clamped;
                shd_oneshot <= wr_oneshot;
                pending     <= 1'b1;
            end
        end
    end

    assign busy = (state == RUN);
    assign out  = ((state == RUN) ? act_pattern[idx] : 1'b0) ^ POL;

endmodule

// File: rtl/pattern_sequencer.sv
// Multi-channel pattern sequencer: shared prescaler, load demux and
// ready mux around CHANNELS independent pattern_channel instances.
module pattern_sequencer
    import pattern_sequencer_pkg::*;
#(
    parameter int                  CHANNELS = 2,
    parameter int                  PAT_LEN  = 32,
    parameter int                  PRESCALE = 2097152,
    parameter logic [CHANNELS-1:0] POLARITY = '0,
    localparam int                 LEN_W    = width_of(PAT_LEN),
    localparam int                 SEL_W    = width_of(CHANNELS)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                load_valid,
    output logic                load_ready,
    input  logic [SEL_W-1:0]    load_chan,
    input  logic [PAT_LEN-1:0]  load_pattern,
    input  logic [LEN_W-1:0]    load_len,
    input  logic                load_oneshot,
    input  logic [CHANNELS-1:0] stop,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] done
);

    localparam int CNT_W = width_of(PRESCALE);
    localparam int NSEL  = 1 << SEL_W;

    logic [CNT_W-1:0]    count;
    logic                tick;
    logic                xfer;
    logic [CHANNELS-1:0] pending;
    logic [NSEL-1:0]     pend_ext;

    assign tick = (count == CNT_W'(PRESCALE - 1));

    // Free-running step prescaler shared by every channel.
    always_ff @(posedge CLK) begin
        if (RST) begin
            count <= '0;
        end else if (tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    // Unpopulated channel selects read as permanently busy, so a load to a
    // channel that does not exist is never accepted.
    always_comb begin
        pend_ext                 = '1;
        pend_ext[CHANNELS-1:0]   = pending;
    end

    assign load_ready = ~pend_ext[load_chan];
    assign xfer       = load_valid && load_ready;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        pattern_channel #(
            .PAT_LEN (PAT_LEN),
            .LEN_W   (LEN_W),
            .POL     (POLARITY[c])
        ) u_chan (
            .clk        (CLK),
            .rst        (RST),
            .tick       (tick),
            .wr         (xfer && (load_chan == SEL_W'(c))),
            .wr_pattern (load_pattern),
            .wr_len     (load_len),
            .wr_oneshot (load_oneshot),
            .stop       (stop[c]),
            .pending    (pending[c]),
            .out        (out[c]),
            .busy       (busy[c]),
            .done       (done[c])
        );
    end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer with PRESCALE=4, PAT_LEN=8,
// CHANNELS=2, POLARITY=2'b10.
module tb_pattern_sequencer;

    logic       CLK;
    logic       RST;
    logic       load_valid;
    logic       load_ready;
    logic [0:0] load_chan;
    logic [7:0] load_pattern;
    logic [2:0] load_len;
    logic       load_oneshot;
    logic [1:0] stop;
    logic [1:0] out;
    logic [1:0] busy;
    logic [1:0] done;

    int n_pass  = 0;
    int n_total = 0;
    int done_cnt0 = 0;
    int done_cnt1 = 0;

    pattern_sequencer #(
        .CHANNELS (2),
        .PAT_LEN  (8),
        .PRESCALE (4),
        .POLARITY (2'b10)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .load_chan    (load_chan),
        .load_pattern (load_pattern),
        .load_len     (load_len),
        .load_oneshot (load_oneshot),
        .stop         (stop),
        .out          (out),
        .busy         (busy),
        .done         (done)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Count every cycle in which a done bit is high, outside reset.
    always @(negedge CLK) begin
        if (!RST) begin
            done_cnt0 += int'(done[0]);
            done_cnt1 += int'(done[1]);
        end
    end

    typedef struct {
        logic       lv;
        logic       lch;
        logic [7:0] pat;
        logic [2:0] len;
        logic       os;
        logic [1:0] stp;
        int         adv;
        logic [1:0] eo;
        logic [1:0] eb;
        logic [1:0] ed;
        logic       er;
    } row_t;

    row_t rows[31];

    function automatic row_t mk(logic lv, logic lch, logic [7:0] pat, logic [2:0] len,
                                logic os, logic [1:0] stp, int adv, logic [1:0] eo,
                                logic [1:0] eb, logic [1:0] ed, logic er);
        row_t r;
        r.lv = lv; r.lch = lch; r.pat = pat; r.len = len; r.os = os; r.stp = stp;
        r.adv = adv; r.eo = eo; r.eb = eb; r.ed = ed; r.er = er;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        load_valid   = 1'b0;
        load_pattern = 8'h00;
        load_len     = 3'd0;
        load_oneshot = 1'b0;
        stop         = 2'b00;
    endtask

    task automatic check_all(input string tag, input logic [1:0] eo, input logic [1:0] eb,
                             input logic [1:0] ed, input logic er);
        check({tag, " out"}, 32'(out), 32'(eo));
        check({tag, " busy"}, 32'(busy), 32'(eb));
        check({tag, " done"}, 32'(done), 32'(ed));
        check({tag, " ready"}, 32'(load_ready), 32'(er));
    endtask

    initial begin
        // Row n = cycles after the 20-cycle idle hold; ticks land on n % 4 == 0.
        //             lv lch pat    len  os stp  adv eo     eb     ed     er
        rows[0]  = mk(0, 0, 8'h00, 3'd0, 0, 2'b00, 2, 2'b10, 2'b00, 2'b00, 1);
        rows[1]  = mk(1, 0, 8'h0D, 3'd3, 0, 2'b00, 1, 2'b10, 2'b00, 2'b00, 0);
        rows[2]  = mk(0, 0, 8'h00, 3'd0, 0, 2'b00, 1, 2'b11, 2'b01, 2'b00, 1);
        rows[3]  = mk(0, 0, 8'h00, 3'd0, 0, 2'b00, 4, 2'b10, 2'b01, 2'b00, 1);
        rows[4]  = mk(0, 0, 8'h00, 3'd0, 0, 2'b00, 4, 2'b11, 2'b01, 2'b00, 1);
        rows[5]  = mk(0, 0, 8'h00, 3'd0, 0, 2'b00, 4, 2'b11, 2'b01, 2'b00, 1);
        rows[6]  = mk(0, 0, 8'h00, 3'd0, 0, 2'b00, 4, 2'b11, 2'b01, 2'b00, 1);
        rows[7]  = mk(0, 0, 8'h00, 3'd0, 0, 2'b00, 4, 2'b10, 2'b01, 2'b00, 1);
        rows[8]  = mk(0, 1, 8'h00, 3'd0, 0, 2'b00, 2, 2'b10, 2'b01, 2'b00, 1);
        rows[9]  = mk(1, 1, 8'h03, 3'd1, 1, 2'b00, 1, 2'b10, 2'b01, 2'b00, 0);
        rows[10] = mk(0, 1, 8'h00, 3'd0, 0, 2'b00, 1, 2'b01, 2'b11, 2'b00, 1);
        rows[11] = mk(0, 1, 8'h00, 3'd0, 0, 2'b00, 4, 2'b01, 2'b11, 2'b00, 1);
        rows[12] = mk(0, 1, 8'h00, 3'd0, 0, 2'b00, 3, 2'b01, 2'b11, 2'b00, 1);
        rows[13] = mk(0, 1, 8'h00, 3'd0, 0, 2'b00, 1, 2'b11, 2'b01, 2'b10, 1);
        rows[14] = mk(0, 1, 8'h00, 3'd0, 0, 2'b00, 1, 2'b11, 2'b01, 2'b00, 1);
        rows[15] = mk(1, 0, 8'hF0, 3'd7, 0, 2'b00, 1, 2'b11, 2'b01, 2'b00, 0);
        rows[16] = mk(1, 0, 8'hFF, 3'd0, 1, 2'b00, 1, 2'b11, 2'b01, 2'b00, 0);
        rows[17] = mk(0, 0, 8'h00, 3'd0, 0, 2'b00, 1, 2'b10, 2'b01, 2'b00, 0);
        rows[18] = mk(0, 0, 8'h00, 3'd0, 0, 2'b00, 11, 2'b11, 2'b01, 2'b00, 0);
        rows[19] = mk(0, 0, 8'h00, 3'd0, 0, 2'b00, 1, 2'b10, 2'b01, 2'b00, 1);
        rows[20] = mk(0, 0, 8'h00, 3'd0, 0, 2'b00, 15, 2'b10, 2'b01, 2'b00, 1);
        rows[21] = mk(0, 0, 8'h00, 3'd0, 0, 2'b00, 1, 2'b11, 2'b01, 2'b00, 1);
        rows[22] = mk(0, 0, 8'h00, 3'd0, 0, 2'b00, 1, 2'b11, 2'b01, 2'b00, 1);
        rows[23] = mk(1, 0, 8'h55, 3'd2, 0, 2'b00, 1, 2'b11, 2'b01, 2'b00, 0);
        rows[24] = mk(0, 0, 8'h00, 3'd0, 0, 2'b01, 1, 2'b10, 2'b00, 2'b00, 1);
        rows[25] = mk(0, 0, 8'h00, 3'd0, 0, 2'b00, 5, 2'b10, 2'b00, 2'b00, 1);
        rows[26] = mk(1, 0, 8'h01, 3'd0, 0, 2'b01, 1, 2'b10, 2'b00, 2'b00, 0);
        rows[27] = mk(0, 0, 8'h00, 3'd0, 0, 2'b00, 1, 2'b11, 2'b01, 2'b00, 1);
        rows[28] = mk(1, 1, 8'h02, 3'd1, 0, 2'b00, 2, 2'b11, 2'b11, 2'b00, 1);
        rows[29] = mk(0, 1, 8'h00, 3'd0, 0, 2'b00, 4, 2'b01, 2'b11, 2'b00, 1);
        rows[30] = mk(0, 1, 8'h00, 3'd0, 0, 2'b00, 1, 2'b01, 2'b11, 2'b00, 1);

        RST = 1'b1;
        load_chan = 1'b0;
        idle_inputs();
        repeat (3) step();
        RST = 1'b0;
        check_all("reset", 2'b10, 2'b00, 2'b00, 1'b1);

        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("hold%0d out", i), 32'(out), 32'h2);
            check($sformatf("hold%0d busy", i), 32'(busy), 32'h0);
            check($sformatf("hold%0d done", i), 32'(done), 32'h0);
        end

        for (int i = 0; i < 31; i++) begin
            load_valid   = rows[i].lv;
            load_chan    = rows[i].lch;
            load_pattern = rows[i].pat;
            load_len     = rows[i].len;
            load_oneshot = rows[i].os;
            stop         = rows[i].stp;
            step();
            load_valid = 1'b0;
            stop       = 2'b00;
            for (int k = 1; k < rows[i].adv; k++) step();
            check_all($sformatf("row%0d", i), rows[i].eo, rows[i].eb, rows[i].ed, rows[i].er);
        end

        // Mid-run reset on both channels, then a load that must start from
        // idx 0 with the prescaler restarted.
        RST = 1'b1;
        step();
        RST = 1'b0;
        load_chan = 1'b0;
        check_all("midrst", 2'b10, 2'b00, 2'b00, 1'b1);
        load_chan = 1'b1;
        check("midrst ready ch1", 32'(load_ready), 32'h1);
        load_chan    = 1'b0;
        load_valid   = 1'b1;
        load_pattern = 8'h06;
        load_len     = 3'd2;
        load_oneshot = 1'b0;
        step();
        load_valid = 1'b0;
        step();
        check("post m2 out", 32'(out), 32'h2);
        check("post m2 busy", 32'(busy), 32'h1);
        step();
        check("post m3 out", 32'(out), 32'h2);
        step();
        check("post m4 out", 32'(out), 32'h3);

        check("done0 pulse count", 32'(done_cnt0), 32'd0);
        check("done1 pulse count", 32'(done_cnt1), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
